// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - VGA 640x480@60 default timing constants and helpers
package vga_timing_pkg;

  localparam int DEF_COUNT_W  = 10;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;

  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  localparam int DEF_H_SYNC_POL = 0;
  localparam int DEF_V_SYNC_POL = 0;

  // Positions along one axis: active, front porch, sync, back porch.
  function automatic int axis_total(input int active, input int fp, input int sync,
                                    input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// rtl/vga_timing_gen_if.sv - timing outputs bundle from generator to pixel pipeline
interface vga_timing_gen_if #(
  parameter int COUNT_W = 10
);

  logic [COUNT_W-1:0] o_Col_Count;
  logic [COUNT_W-1:0] o_Row_Count;
  logic               o_HSync;
  logic               o_VSync;
  logic               o_Active;
  logic               o_Line_Start;
  logic               o_Frame_Start;

  modport master (
    output o_Col_Count,
    output o_Row_Count,
    output o_HSync,
    output o_VSync,
    output o_Active,
    output o_Line_Start,
    output o_Frame_Start
  );

  modport slave (
    input o_Col_Count,
    input o_Row_Count,
    input o_HSync,
    input o_VSync,
    input o_Active,
    input o_Line_Start,
    input o_Frame_Start
  );

endinterface

// File: rtl/vga_axis_counter.sv
// rtl/vga_axis_counter.sv - one timing axis: position counter with sync/active decode
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int W      = 10,
  parameter int ACTIVE = 640,
  parameter int FP     = 16,
  parameter int SYNC   = 96,
  parameter int BP     = 48,
  parameter int POL    = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         advance,
  output logic [W-1:0] count,
  output logic         sync,
  output logic         active,
  output logic         wrap_next
);

  localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP);

  if (TOTAL > (2 ** W)) begin : g_chk_total
    $error("vga_axis_counter: total %0d does not fit in %0d bits", TOTAL, W);
  end
  if (ACTIVE < 1 || FP < 1 || SYNC < 1 || BP < 1) begin : g_chk_len
    $error("vga_axis_counter: every region must be at least 1 long");
  end
  if (POL != 0 && POL != 1) begin : g_chk_pol
    $error("vga_axis_counter: POL must be 0 or 1, got %0d", POL);
  end

  localparam logic [W-1:0] LAST       = W'(TOTAL - 1);
  localparam logic [W-1:0] ACTIVE_END = W'(ACTIVE);
  localparam logic [W-1:0] SYNC_BEGIN = W'(ACTIVE + FP);
  localparam logic [W-1:0] SYNC_END   = W'(ACTIVE + FP + SYNC);
  localparam logic         ASSERTED   = 1'(POL);

  logic [W-1:0] count_q;
  logic [W-1:0] count_nxt;

  assign count     = count_q;
  assign wrap_next = (count_q == LAST);

  always_comb begin
    count_nxt = count_q;
    if (advance) begin
      count_nxt = wrap_next ? '0 : count_q + W'(1);
    end
  end

  // Flags decode the next count so they change on the same edge as the counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      sync    <= ~ASSERTED;
      active  <= 1'b1;
    end else if (advance) begin
      count_q <= count_nxt;
      sync    <= (count_nxt >= SYNC_BEGIN && count_nxt < SYNC_END) ? ASSERTED : ~ASSERTED;
      active  <= (count_nxt < ACTIVE_END);
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA timing generator advancing on a pixel-enable strobe
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int COUNT_W    = DEF_COUNT_W,
  parameter int H_ACTIVE   = DEF_H_ACTIVE,
  parameter int H_FP       = DEF_H_FP,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BP       = DEF_H_BP,
  parameter int V_ACTIVE   = DEF_V_ACTIVE,
  parameter int V_FP       = DEF_V_FP,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BP       = DEF_V_BP,
  parameter int H_SYNC_POL = DEF_H_SYNC_POL,
  parameter int V_SYNC_POL = DEF_V_SYNC_POL
) (
  input  logic              i_Clk,
  input  logic              i_Rst_L,
  input  logic              i_Pix_En,
  vga_timing_gen_if.master  vga
);

  logic h_wrap_next;
  logic v_wrap_next;
  logic h_active;
  logic v_active;
  logic v_advance;

  assign v_advance = i_Pix_En & h_wrap_next;

  vga_axis_counter #(
    .W      (COUNT_W),
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP),
    .POL    (H_SYNC_POL)
  ) u_horiz (
    .clk       (i_Clk),
    .rst_n     (i_Rst_L),
    .advance   (i_Pix_En),
    .count     (vga.o_Col_Count),
    .sync      (vga.o_HSync),
    .active    (h_active),
    .wrap_next (h_wrap_next)
  );

  vga_axis_counter #(
    .W      (COUNT_W),
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP),
    .POL    (V_SYNC_POL)
  ) u_vert (
    .clk       (i_Clk),
    .rst_n     (i_Rst_L),
    .advance   (v_advance),
    .count     (vga.o_Row_Count),
    .sync      (vga.o_VSync),
    .active    (v_active),
    .wrap_next (v_wrap_next)
  );

  assign vga.o_Active = h_active & v_active;

  // Strobes mark the cycle right after a wrapping advance, so they stay one clock wide.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      vga.o_Line_Start  <= 1'b0;
      vga.o_Frame_Start <= 1'b0;
    end else begin
      vga.o_Line_Start  <= v_advance;
      vga.o_Frame_Start <= v_advance & v_wrap_next;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - directed self-checking bench for vga_timing_gen
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pix_en = 1'b0;

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  vga_timing_gen_if #(.COUNT_W(4))  vs ();
  vga_timing_gen_if #(.COUNT_W(10)) vd ();

  vga_timing_gen #(
    .COUNT_W(4), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .H_SYNC_POL(1), .V_SYNC_POL(1)
  ) dut_s (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_Pix_En(pix_en), .vga(vs)
  );

  vga_timing_gen dut_d (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_Pix_En(pix_en), .vga(vd)
  );

  // Reference positions: small 14x8 raster and default 800x525 raster.
  int   sc = 0, sr = 0, dc = 0, dr = 0;
  logic s_line = 1'b0, s_frame = 1'b0, d_line = 1'b0, d_frame = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sc <= 0; sr <= 0; dc <= 0; dr <= 0;
      s_line <= 1'b0; s_frame <= 1'b0; d_line <= 1'b0; d_frame <= 1'b0;
    end else begin
      s_line <= 1'b0; s_frame <= 1'b0; d_line <= 1'b0; d_frame <= 1'b0;
      if (pix_en) begin
        if (sc == 13) begin
          sc <= 0; s_line <= 1'b1;
          if (sr == 7) begin sr <= 0; s_frame <= 1'b1; end
          else sr <= sr + 1;
        end else sc <= sc + 1;
        if (dc == 799) begin
          dc <= 0; d_line <= 1'b1;
          if (dr == 524) begin dr <= 0; d_frame <= 1'b1; end
          else dr <= dr + 1;
        end else dc <= dc + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("s_col",    32'(vs.o_Col_Count), sc);
    chk("s_row",    32'(vs.o_Row_Count), sr);
    chk("s_hsync",  32'(vs.o_HSync),  32'(sc >= 10 && sc <= 12));
    chk("s_vsync",  32'(vs.o_VSync),  32'(sr >= 5 && sr <= 6));
    chk("s_active", 32'(vs.o_Active), 32'(sc < 8 && sr < 4));
    chk("s_line",   32'(vs.o_Line_Start),  32'(s_line));
    chk("s_frame",  32'(vs.o_Frame_Start), 32'(s_frame));
    chk("d_col",    32'(vd.o_Col_Count), dc);
    chk("d_row",    32'(vd.o_Row_Count), dr);
    chk("d_hsync",  32'(vd.o_HSync),  32'(!(dc >= 656 && dc <= 751)));
    chk("d_vsync",  32'(vd.o_VSync),  32'(!(dr >= 490 && dr <= 491)));
    chk("d_active", 32'(vd.o_Active), 32'(dc < 640 && dr < 480));
    chk("d_line",   32'(vd.o_Line_Start),  32'(d_line));
    chk("d_frame",  32'(vd.o_Frame_Start), 32'(d_frame));
  endtask

  task automatic check_reset_values();
    chk("rst_s_col",    32'(vs.o_Col_Count), 0);
    chk("rst_s_row",    32'(vs.o_Row_Count), 0);
    chk("rst_s_hsync",  32'(vs.o_HSync), 0);
    chk("rst_s_vsync",  32'(vs.o_VSync), 0);
    chk("rst_s_active", 32'(vs.o_Active), 1);
    chk("rst_s_line",   32'(vs.o_Line_Start), 0);
    chk("rst_s_frame",  32'(vs.o_Frame_Start), 0);
    chk("rst_d_col",    32'(vd.o_Col_Count), 0);
    chk("rst_d_row",    32'(vd.o_Row_Count), 0);
    chk("rst_d_hsync",  32'(vd.o_HSync), 1);
    chk("rst_d_vsync",  32'(vd.o_VSync), 1);
    chk("rst_d_active", 32'(vd.o_Active), 1);
    chk("rst_d_line",   32'(vd.o_Line_Start), 0);
  endtask

  int d_hs_low;
  int s_vs_high;
  int s_lines;
  int s_frames;
  int d_lines;

  initial begin
    // Reset held with pix_en high: outputs must stay at reset values.
    rst_n  = 1'b0;
    pix_en = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_values();

    // Continuous enable: 1700 cycles covers two default lines and 15 small frames.
    rst_n = 1'b1;
    d_hs_low = 0; s_vs_high = 0; s_lines = 0; s_frames = 0; d_lines = 0;
    for (int i = 1; i <= 1700; i++) begin
      @(negedge clk);
      if (i == 1) begin
        chk("first_col_s", 32'(vs.o_Col_Count), 1);
        chk("first_col_d", 32'(vd.o_Col_Count), 1);
        chk("release_line", 32'(vs.o_Line_Start | vd.o_Line_Start), 0);
      end
      check_all();
      if (vd.o_HSync == 1'b0) d_hs_low++;
      if (vs.o_VSync == 1'b1) s_vs_high++;
      if (vs.o_Line_Start) s_lines++;
      if (vs.o_Frame_Start) s_frames++;
      if (vd.o_Line_Start) d_lines++;
    end
    chk("d_hsync_low_cycles", d_hs_low, 192);
    chk("s_vsync_high_cycles", s_vs_high, 420);
    chk("s_line_pulses", s_lines, 121);
    chk("s_frame_pulses", s_frames, 15);
    chk("d_line_pulses", d_lines, 2);
    pix_en = 1'b0;

    // Enable every other clock: small raster advances 20 -> 356 (3 frame wraps, 24 lines).
    s_lines = 0; s_frames = 0;
    for (int i = 0; i < 672; i++) begin
      @(negedge clk);
      check_all();
      if (vs.o_Line_Start) s_lines++;
      if (vs.o_Frame_Start) s_frames++;
      pix_en = (i % 2 == 0);
    end
    chk("sparse_line_cycles", s_lines, 24);
    chk("sparse_frame_cycles", s_frames, 3);
    chk("sparse_s_col_end", 32'(vs.o_Col_Count), 356 % 14);
    chk("sparse_s_row_end", 32'(vs.o_Row_Count), (356 / 14) % 8);

    // Mid-frame asynchronous reset, then release with enable high.
    pix_en = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check_all();
    end
    #2 rst_n = 1'b0;
    #1 check_reset_values();
    @(negedge clk);
    check_reset_values();
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_s_col", 32'(vs.o_Col_Count), 1);
    chk("post_rst_d_col", 32'(vd.o_Col_Count), 1);
    chk("post_rst_line",  32'(vs.o_Line_Start | vd.o_Line_Start), 0);
    chk("post_rst_frame", 32'(vs.o_Frame_Start | vd.o_Frame_Start), 0);
    check_all();
    repeat (20) begin
      @(negedge clk);
      check_all();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised VGA timing generator. It produces column/row counters, HSync/VSync with configurable porches and polarity, an active-video flag, and line/frame start strobes. It advances only on a pixel-enable strobe, so it runs from a faster system clock. It sits between the clock domain logic and the pixel pipeline, feeding pattern/framebuffer blocks and the VGA output registers.

Parameters:
COUNT_W, 10, width of column/row counters
H_ACTIVE, 640, visible columns
H_FP, 16, horizontal front porch (columns)
H_SYNC, 96, horizontal sync width (columns)
H_BP, 48, horizontal back porch (columns)
V_ACTIVE, 480, visible rows
V_FP, 10, vertical front porch (rows)
V_SYNC, 2, vertical sync width (rows)
V_BP, 33, vertical back porch (rows)
H_SYNC_POL, 0, HSync asserted level (0 = active-low)
V_SYNC_POL, 0, VSync asserted level (0 = active-low)

Ports:
i_Clk  input  1  system clock
i_Rst_L  input  1  asynchronous active-low reset
i_Pix_En  input  1  pixel strobe; counters advance only in cycles where this is 1
o_Col_Count  output  COUNT_W  current column, 0..H_TOTAL-1
o_Row_Count  output  COUNT_W  current row, 0..V_TOTAL-1
o_HSync  output  1  horizontal sync at H_SYNC_POL level while asserted
o_VSync  output  1  vertical sync at V_SYNC_POL level while asserted
o_Active  output  1  1 when col < H_ACTIVE and row < V_ACTIVE
o_Line_Start  output  1  one-clock pulse after column wraps to 0
o_Frame_Start  output  1  one-clock pulse after (col,row) wraps to (0,0)

Behaviour:
- Derived values: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL defined likewise. Column order: active, front porch, sync, back porch. Rows use the same order.
- Reset (async, i_Rst_L=0): counts are 0,0. o_Active=1. o_HSync=~H_SYNC_POL. o_VSync=~V_SYNC_POL. o_Line_Start=0. o_Frame_Start=0. Outputs hold reset values while reset is low.
- The first advance after reset release is on the first i_Clk edge with i_Pix_En=1.
- Counting on an i_Clk edge with i_Pix_En=1:
  - col = H_TOTAL-1 wraps col to 0. In that case, row increments, or wraps to 0 when row = V_TOTAL-1.
  - Otherwise, col increments.
- With i_Pix_En=0, counts, syncs and o_Active hold.
- Alignment: o_HSync, o_VSync and o_Active are registered. In every cycle they are a pure function of the o_Col_Count/o_Row_Count values presented in that same cycle, with zero skew. Implement this by decoding next-state counts.
- HSync is asserted iff H_ACTIVE+H_FP <= col < H_ACTIVE+H_FP+H_SYNC.
- VSync is asserted iff V_ACTIVE+V_FP <= row < V_ACTIVE+V_FP+V_SYNC. VSync depends on row only, so its edges coincide with col=0.
- o_Line_Start is high for exactly one i_Clk cycle: the cycle in which col first shows 0 after a wrap. It stays one clock wide even when i_Pix_En is sparse.
- o_Frame_Start follows the same rule for a (0,0) wrap and is coincident with o_Line_Start on that cycle.
- Neither strobe fires on reset release.
- Arithmetic: all comparisons are unsigned at COUNT_W bits. Totals are computed as elaboration-time integers.
- Elaboration checks ($error, build fails) trigger on any of these:
  - H_TOTAL > 2**COUNT_W or V_TOTAL > 2**COUNT_W;
  - any ACTIVE, FP, SYNC or BP parameter < 1;
  - a POL parameter not in {0,1}.
- Reset mid-frame immediately forces reset values. There is no partial-line recovery.

Decomposition:
- Package vga_timing_pkg: default 640x480@60 constants (H_ACTIVE..V_BP) and a localparam function computing totals.
- Sub-module vga_axis_counter: one counter plus decode, with params ACTIVE, FP, SYNC, BP, POL, W.
  - Inputs: clk, reset, advance.
  - Outputs: count, sync, active, wrap_next.
- Instantiate it twice in vga_timing_gen:
  - horizontal: advance = i_Pix_En;
  - vertical: advance = i_Pix_En & h_wrap_next.
- The top level combines the two active flags and generates the start strobes.

Test Plan:
1. Defaults, i_Pix_En=1 constantly -> line period 800 clocks. o_HSync=0 exactly at cols 656..751 (96 clocks). o_Active=1 at cols 0..639 of rows 0..479.
2. Defaults, full frame -> row wraps after 525 lines. o_VSync=0 for rows 490..491 (1600 clocks). o_Frame_Start is one clock wide, once per 420000 clocks, coincident with o_Line_Start.
3. i_Pix_En high every other clock -> counts and flags hold on disabled clocks. Frame period is 840000 clocks. o_Line_Start/o_Frame_Start are still exactly 1 clock wide.
4. Assert i_Rst_L=0 asynchronously at col=300, row=200 -> outputs reach reset values before the next edge. After release, col=1 appears on the first i_Pix_En edge. No start strobe fires.
5. Params H=8/2/3/1, V=4/1/2/1, both POL=1, COUNT_W=4 -> o_HSync=1 exactly at cols 10..12 and o_VSync=1 at rows 5..6. Bench compares every cycle of three frames against a reference model.
6. Params giving H_TOTAL=1025 with COUNT_W=10 -> elaboration error reported.
